// File: rtl/count_checker_pkg.sv
// Shared types and default sizing for the counter sequence checker.
package count_checker_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACQUIRE,
    LOCKED
  } state_e;

  localparam int unsigned DEF_WIDTH    = 8;
  localparam int unsigned DEF_LOCK_LEN = 4;
  localparam int unsigned DEF_WRAP_W   = 16;
  localparam int unsigned DEF_ERR_W    = 8;

endpackage

// File: rtl/count_checker_sat_counter.sv
// Saturating up-counter: clr has priority over inc; holds at all-ones.
// Registered output, 1-cycle latency; no backpressure.
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != {W{1'b1}})) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/count_checker.sv
// Checks a free-running counter for +1 steps; all status registered (1 cycle after the sample).
// No backpressure. Optional sticky error flag built only with COUNT_CHECKER_STICKY_EN.
module count_checker
  import count_checker_pkg::*;
#(
  parameter int unsigned WIDTH    = DEF_WIDTH,
  parameter int unsigned LOCK_LEN = DEF_LOCK_LEN,
  parameter int unsigned WRAP_W   = DEF_WRAP_W,
  parameter int unsigned ERR_W    = DEF_ERR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              clear,
  input  logic [WIDTH-1:0]  count_in,
  output logic              locked,
  output logic              error,
  output logic              err_sticky,
  output logic [WRAP_W-1:0] wrap_count,
  output logic [ERR_W-1:0]  err_count,
  output logic [WIDTH-1:0]  last_good
);

  localparam int unsigned RL_W = (LOCK_LEN < 2) ? 1 : $clog2(LOCK_LEN + 1);

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  prev_q, prev_d;
  logic [RL_W-1:0]   run_len_q, run_len_d;
  logic [WIDTH-1:0]  last_good_q, last_good_d;
  logic              error_q, error_d;
  logic              wrap_inc;

  logic [WIDTH-1:0]  exp_val;
  logic [RL_W-1:0]   run_len_inc;
  logic              match;

  assign exp_val     = prev_q + 1'b1;
  assign run_len_inc = run_len_q + 1'b1;
  assign match       = (count_in == exp_val);

  always_comb begin
    state_d     = state_q;
    prev_d      = prev_q;
    run_len_d   = run_len_q;
    last_good_d = last_good_q;
    error_d     = 1'b0;
    wrap_inc    = 1'b0;

    if (!enable) begin
      // Dropping enable forces re-acquisition; history is kept.
      state_d = IDLE;
    end else begin
      prev_d = count_in;
      unique case (state_q)
        IDLE: begin
          run_len_d = '0;
          state_d   = ACQUIRE;
        end
        ACQUIRE: begin
          if (match) begin
            run_len_d   = run_len_inc;
            last_good_d = count_in;
            if (run_len_inc == RL_W'(LOCK_LEN)) begin
              state_d = LOCKED;
            end
          end else begin
            run_len_d = '0;
          end
        end
        LOCKED: begin
          if (match) begin
            last_good_d = count_in;
            wrap_inc    = (prev_q == {WIDTH{1'b1}}) && (count_in == '0);
          end else begin
            error_d   = 1'b1;
            run_len_d = '0;
            state_d   = ACQUIRE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      prev_q      <= '0;
      run_len_q   <= '0;
      last_good_q <= '0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      prev_q      <= prev_d;
      run_len_q   <= run_len_d;
      last_good_q <= last_good_d;
      error_q     <= error_d;
    end
  end

  sat_counter #(.W(WRAP_W)) u_wrap_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (wrap_inc),
    .clr   (clear),
    .count (wrap_count)
  );

  sat_counter #(.W(ERR_W)) u_err_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (error_d),
    .clr   (clear),
    .count (err_count)
  );

`ifdef COUNT_CHECKER_STICKY_EN
  logic sticky_q, sticky_d;

  always_comb begin
    sticky_d = sticky_q | error_d;
    if (clear) begin
      sticky_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_q <= 1'b0;
    end else begin
      sticky_q <= sticky_d;
    end
  end

  assign err_sticky = sticky_q;
`else
  assign err_sticky = 1'b0;
`endif

  assign locked    = (state_q == LOCKED);
  assign error     = error_q;
  assign last_good = last_good_q;

endmodule

// File: tb/tb_count_checker.sv
// Directed bench for count_checker; err_sticky expectation follows COUNT_CHECKER_STICKY_EN.
module tb_count_checker;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        clear;
  logic [7:0]  count_in;
  logic        locked;
  logic        error;
  logic        err_sticky;
  logic [15:0] wrap_count;
  logic [7:0]  err_count;
  logic [7:0]  last_good;

  int tests = 0;
  int fails = 0;
  logic [7:0] x;

`ifdef COUNT_CHECKER_STICKY_EN
  localparam logic STK = 1'b1;
`else
  localparam logic STK = 1'b0;
`endif

  count_checker dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .clear      (clear),
    .count_in   (count_in),
    .locked     (locked),
    .error      (error),
    .err_sticky (err_sticky),
    .wrap_count (wrap_count),
    .err_count  (err_count),
    .last_good  (last_good)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Apply one sample at the falling edge; return 1 time unit after the rising edge.
  task automatic drive(input logic en, input logic clr, input logic [7:0] v);
    @(negedge clk);
    enable   = en;
    clear    = clr;
    count_in = v;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; clear = 1'b0; count_in = '0;
    #12;
    chk("rst_locked",  32'(locked), 0);
    chk("rst_error",   32'(error), 0);
    chk("rst_sticky",  32'(err_sticky), 0);
    chk("rst_wrap",    32'(wrap_count), 0);
    chk("rst_err",     32'(err_count), 0);
    chk("rst_lastgood", 32'(last_good), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Initial acquisition: 120 seeds, 121..124 are the four matches.
    for (int v = 120; v <= 123; v++) drive(1'b1, 1'b0, 8'(v));
    chk("acq_not_yet", 32'(locked), 0);
    drive(1'b1, 1'b0, 8'd124);
    chk("acq_locked",   32'(locked), 1);
    chk("acq_lastgood", 32'(last_good), 124);
    chk("acq_wrap0",    32'(wrap_count), 0);
    chk("acq_err0",     32'(err_count), 0);
    chk("acq_error0",   32'(error), 0);

    // Wrap through 255 -> 0 while locked.
    for (int v = 125; v <= 255; v++) drive(1'b1, 1'b0, 8'(v));
    chk("wrap_before", 32'(wrap_count), 0);
    drive(1'b1, 1'b0, 8'd0);
    chk("wrap_one",    32'(wrap_count), 1);
    drive(1'b1, 1'b0, 8'd1);
    chk("wrap_hold",   32'(wrap_count), 1);
    chk("wrap_locked", 32'(locked), 1);
    chk("wrap_noerr",  32'(error), 0);

    // Skip 129: mismatch while locked.
    for (int v = 2; v <= 128; v++) drive(1'b1, 1'b0, 8'(v));
    drive(1'b1, 1'b0, 8'd130);
    chk("mm_error",    32'(error), 1);
    chk("mm_errcnt",   32'(err_count), 1);
    chk("mm_unlock",   32'(locked), 0);
    chk("mm_lastgood", 32'(last_good), 128);
    chk("mm_sticky",   32'(err_sticky), 32'(STK));
    drive(1'b1, 1'b0, 8'd131);
    chk("mm_pulse_end", 32'(error), 0);
    drive(1'b1, 1'b0, 8'd132);
    drive(1'b1, 1'b0, 8'd133);
    chk("relock_not_yet", 32'(locked), 0);
    drive(1'b1, 1'b0, 8'd134);
    chk("relock", 32'(locked), 1);
    drive(1'b1, 1'b0, 8'd135);
    chk("relock_hold",     32'(locked), 1);
    chk("relock_lastgood", 32'(last_good), 135);
    chk("sticky_hold",     32'(err_sticky), 32'(STK));

    // 254 more mismatches, each followed by a 4-match relock, fills err_count.
    x = 8'd135;
    repeat (254) begin
      x = x + 8'd2;
      drive(1'b1, 1'b0, x);
      repeat (4) begin
        x = x + 8'd1;
        drive(1'b1, 1'b0, x);
      end
    end
    chk("sat_full",   32'(err_count), 255);
    chk("sat_locked", 32'(locked), 1);
    x = x + 8'd2;
    drive(1'b1, 1'b0, x);
    chk("sat_hold",  32'(err_count), 255);
    chk("sat_error", 32'(error), 1);
    repeat (4) begin
      x = x + 8'd1;
      drive(1'b1, 1'b0, x);
    end
    chk("sat_relock", 32'(locked), 1);

    // Clear on a matching sample.
    x = x + 8'd1;
    drive(1'b1, 1'b1, x);
    chk("clr_err",    32'(err_count), 0);
    chk("clr_wrap",   32'(wrap_count), 0);
    chk("clr_sticky", 32'(err_sticky), 0);
    chk("clr_locked", 32'(locked), 1);

    // Clear and mismatch together: count ends at 0 but the pulse still fires.
    x = x + 8'd2;
    drive(1'b1, 1'b1, x);
    chk("clrmm_err",   32'(err_count), 0);
    chk("clrmm_error", 32'(error), 1);
    repeat (4) begin
      x = x + 8'd1;
      drive(1'b1, 1'b0, x);
    end
    chk("clrmm_relock", 32'(locked), 1);
    chk("clrmm_errcnt", 32'(err_count), 0);

    // Enable low for three cycles while locked.
    drive(1'b0, 1'b0, 8'h55);
    chk("dis_unlock",   32'(locked), 0);
    chk("dis_lastgood", 32'(last_good), 32'(x));
    drive(1'b0, 1'b0, 8'h00);
    drive(1'b0, 1'b0, 8'hAA);
    chk("dis_still",  32'(locked), 0);
    chk("dis_errcnt", 32'(err_count), 0);
    chk("dis_noerr",  32'(error), 0);
    chk("dis_hold_lg", 32'(last_good), 32'(x));

    // Fresh stream: 10 seeds, 11..14 relock.
    for (int v = 10; v <= 13; v++) drive(1'b1, 1'b0, 8'(v));
    chk("fresh_not_yet", 32'(locked), 0);
    drive(1'b1, 1'b0, 8'd14);
    chk("fresh_locked",   32'(locked), 1);
    chk("fresh_errcnt",   32'(err_count), 0);
    chk("fresh_noerr",    32'(error), 0);
    chk("fresh_lastgood", 32'(last_good), 14);

    // Asynchronous reset mid-operation.
    @(negedge clk);
    count_in = 8'd15;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_locked",   32'(locked), 0);
    chk("arst_lastgood", 32'(last_good), 0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
